orient_to_position: RTL
=======================

# orient_to_position

Consumes the 32-bit orientation word produced by the button-to-orientation stage and advances one light-bike's position across the 640×480 playfield at a fixed move rate. Before every step it reads the trail framebuffer at the candidate pixel through a request/acknowledge port and reports a crash on a wall or trail hit. Its outputs drive the trail writer and the game-over logic.

## Interface
- `WIDTH`, 640, playfield columns; the orientation step values are ±1 and ±WIDTH.
- `HEIGHT`, 480, playfield rows.
- `START_X`, 320, column loaded on start.
- `START_Y`, 240, row loaded on start.
- `TICK_DIV`, 500000, clock cycles spent in RUN per move; must be ≥2.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; starts or restarts the bike.
- `orient`  in  32  step word: 1 = right, 32'hFFFFFFFF = left, 640 = down, 32'hFFFFFD80 = up.
- `rd_req`  out  1  framebuffer occupancy read request.
- `rd_addr`  out  19  candidate pixel address, `y*WIDTH+x`.
- `rd_ack`  in  1  read acknowledge.
- `rd_data`  in  1  occupancy bit for `rd_addr`; valid only while `rd_ack` is high.
- `x`  out  10  current column.
- `y`  out  9  current row.
- `addr`  out  19  current pixel address, `y*WIDTH+x`.
- `step_valid`  out  1  one-cycle pulse when `x`/`y`/`addr` take a new position.
- `running`  out  1  high in RUN or CHECK.
- `crashed`  out  1  high in CRASH.

## Operation
- States:
  - IDLE: reset state.
  - RUN: tick counter counts 0..TICK_DIV-1.
  - CHECK: occupancy read in progress.
  - CRASH: terminal until the next `start`.
- `start` in IDLE or CRASH:
  - Loads START_X/START_Y and `addr = START_Y*WIDTH+START_X`.
  - Latches the decoded direction; an undecodable `orient` selects down.
  - Clears the tick counter and enters RUN.
- `start` in RUN or CHECK is ignored.
- Direction decode:
  - `orient` is sampled on the RUN→CHECK edge.
  - Any value other than the four legal codes keeps the previously latched direction.
- Next position:
  - x±1 or y±1; `next_addr = addr + orient` (signed add, result truncated to 19 bits).
  - Leaving the playfield: x<0, x≥WIDTH, y<0, y≥HEIGHT.
- Edge handling without wrap:
  - A move that would leave the playfield goes RUN→CRASH directly. No read is issued and the position is unchanged.
- Read handshake in CHECK:
  - `rd_req` rises on entry; `rd_req` and `rd_addr` are held stable until `rd_ack` is sampled high.
  - `rd_req` is low the cycle after the ack.
  - `rd_ack` while `rd_req` is low is ignored.
- Ack outcome:
  - `rd_data=1`: enter CRASH; position unchanged.
  - `rd_data=0`: commit the next position, pulse `step_valid`, return to RUN with the counter at 0.
- Reset values: state IDLE; `x=START_X`, `y=START_Y`, `addr=START_Y*WIDTH+START_X`; direction down; tick counter 0; `rd_req`, `rd_addr`, `step_valid`, `running`, `crashed` all 0.

## Timing
- RUN lasts exactly TICK_DIV cycles, then CHECK is entered.
- `rd_req` is high in the first CHECK cycle.
- `rd_ack` sampled high in cycle k of CHECK (k≥0):
  - new `x`/`y`/`addr` and `step_valid=1` appear at edge k+1;
  - `rd_req` is low from edge k+1.
- Step period = TICK_DIV + k + 1 cycles.
- Crash detection:
  - `crashed` rises at edge k+1 for a trail hit;
  - at the RUN→CHECK edge for a wall hit.
- `step_valid` never occurs in two consecutive cycles.
- `resetn` low mid-CHECK: `rd_req` drops immediately (asynchronously); a pending ack is discarded.

## Configuration
- `ORIENT_WRAP_EN`:
  - Defined: edges wrap instead of crashing.
    - Right from x=WIDTH-1 → x=0, `addr-(WIDTH-1)`.
    - Left from x=0 → x=WIDTH-1, `addr+(WIDTH-1)`.
    - Up from y=0 → y=HEIGHT-1, `addr+(HEIGHT-1)*WIDTH`.
    - Down from y=HEIGHT-1 → y=0, `addr-(HEIGHT-1)*WIDTH`.
    - The wrapped address is read normally; only a trail hit crashes.
  - Undefined: an edge move goes to CRASH as described under Operation.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then `start` with orient=1 and `rd_ack` tied to `rd_req`, `rd_data=0`:
  - `rd_addr`=153921 in the first CHECK cycle;
  - x=321, addr=153921, `step_valid` after 4+1 cycles;
  - second step x=322 five cycles later.
- orient=32'hFFFFFD80 with ack delayed 3 cycles:
  - `rd_req`/`rd_addr`=153280 stable for 4 cycles;
  - y=239, addr=153280 one cycle after the ack;
  - period 8 cycles.
- Trail hit: `rd_data=1` with the ack:
  - `crashed=1`, `running=0`, x/y unchanged, no `step_valid`;
  - a later `start` restores (320,240) and RUN.
- Wall without wrap: START_X=639, orient=1:
  - CRASH after 4 cycles with no `rd_req`.
- Wall with `ORIENT_WRAP_EN`, same setup:
  - `rd_addr`=153600, then x=0, addr=153600.
- Invalid and ignored inputs:
  - orient=5 mid-run keeps the previous direction;
  - `start` during RUN is ignored.
- `resetn` low during CHECK:
  - `rd_req`=0 immediately; all outputs return to their reset values.

Source files
------------

// File: rtl/orient_to_position_if.sv
// Framebuffer occupancy read port between orient_to_position (master) and the
// trail framebuffer (slave).
interface orient_to_position_if;
    // Request/acknowledge: the master raises rd_req with rd_addr and holds both
    // stable until rd_ack is sampled high on a rising edge. rd_data is valid only
    // in that ack cycle. rd_req is low the cycle after the ack, and an ack seen
    // while rd_req is low carries no meaning.
    logic        rd_req;
    logic [18:0] rd_addr;
    logic        rd_ack;
    logic        rd_data;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_ack,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_ack,
        output rd_data
    );
endinterface

// File: rtl/orient_to_position.sv
// Advances one light-bike across the playfield once per TICK_DIV cycles, reading
// the trail framebuffer before each step. Define ORIENT_WRAP_EN to wrap at edges.
module orient_to_position #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int START_X  = 320,
    parameter int START_Y  = 240,
    parameter int TICK_DIV = 500000
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [31:0]          orient,
    orient_to_position_if.master rd,
    output logic [9:0]           x,
    output logic [8:0]           y,
    output logic [18:0]          addr,
    output logic                 step_valid,
    output logic                 running,
    output logic                 crashed,
    output logic [1:0]           dbg_state_o
);

`ifdef ORIENT_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam int          CW         = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [9:0]  START_XV   = 10'(START_X);
    localparam logic [8:0]  START_YV   = 9'(START_Y);
    localparam logic [18:0] START_ADDR = 19'(START_Y * WIDTH + START_X);
    localparam logic [31:0] O_RIGHT    = 32'h0000_0001;
    localparam logic [31:0] O_LEFT     = 32'hFFFF_FFFF;
    localparam logic [31:0] O_DOWN     = 32'(WIDTH);
    localparam logic [31:0] O_UP       = 32'(-WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_CRASH} state_t;
    typedef enum logic [1:0] {D_RIGHT, D_LEFT, D_DOWN, D_UP} dir_t;

    state_t        state_q, state_d;
    dir_t          dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    x_q, x_d, nx_q, nx_d;
    logic [8:0]    y_q, y_d, ny_q, ny_d;
    logic [18:0]   addr_q, addr_d, rd_addr_q, rd_addr_d;
    logic          rd_req_q, rd_req_d;
    logic          step_valid_q, step_valid_d;

    logic          legal;
    dir_t          dec;
    dir_t          mv_dir;
    logic          wall;
    logic [9:0]    cx;
    logic [8:0]    cy;
    logic [18:0]   ca;

    always_comb begin
        legal = 1'b1;
        dec   = D_DOWN;
        case (orient)
            O_RIGHT: dec = D_RIGHT;
            O_LEFT:  dec = D_LEFT;
            O_DOWN:  dec = D_DOWN;
            O_UP:    dec = D_UP;
            default: legal = 1'b0;
        endcase
    end

    // An unrecognised orient word leaves the previous heading in force.
    assign mv_dir = legal ? dec : dir_q;

    always_comb begin
        wall = 1'b0;
        cx   = x_q;
        cy   = y_q;
        ca   = addr_q;
        case (mv_dir)
            D_RIGHT: begin
                if (x_q == 10'(WIDTH - 1)) begin
                    wall = !WRAP_EN;
                    cx   = '0;
                    ca   = addr_q - 19'(WIDTH - 1);
                end else begin
                    cx = x_q + 10'd1;
                    ca = addr_q + 19'd1;
                end
            end
            D_LEFT: begin
                if (x_q == '0) begin
                    wall = !WRAP_EN;
                    cx   = 10'(WIDTH - 1);
                    ca   = addr_q + 19'(WIDTH - 1);
                end else begin
                    cx = x_q - 10'd1;
                    ca = addr_q - 19'd1;
                end
            end
            D_DOWN: begin
                if (y_q == 9'(HEIGHT - 1)) begin
                    wall = !WRAP_EN;
                    cy   = '0;
                    ca   = addr_q - 19'((HEIGHT - 1) * WIDTH);
                end else begin
                    cy = y_q + 9'd1;
                    ca = addr_q + 19'(WIDTH);
                end
            end
            D_UP: begin
                if (y_q == '0) begin
                    wall = !WRAP_EN;
                    cy   = 9'(HEIGHT - 1);
                    ca   = addr_q + 19'((HEIGHT - 1) * WIDTH);
                end else begin
                    cy = y_q - 9'd1;
                    ca = addr_q - 19'(WIDTH);
                end
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        cnt_d        = cnt_q;
        x_d          = x_q;
        y_d          = y_q;
        addr_d       = addr_q;
        nx_d         = nx_q;
        ny_d         = ny_q;
        rd_addr_d    = rd_addr_q;
        rd_req_d     = rd_req_q;
        step_valid_d = 1'b0;
        case (state_q)
            S_IDLE, S_CRASH: begin
                if (start) begin
                    state_d = S_RUN;
                    x_d     = START_XV;
                    y_d     = START_YV;
                    addr_d  = START_ADDR;
                    dir_d   = legal ? dec : D_DOWN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    dir_d = mv_dir;
                    if (wall) begin
                        state_d = S_CRASH;
                    end else begin
                        state_d   = S_CHECK;
                        nx_d      = cx;
                        ny_d      = cy;
                        rd_addr_d = ca;
                        rd_req_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CHECK: begin
                if (rd_req_q && rd.rd_ack) begin
                    rd_req_d = 1'b0;
                    if (rd.rd_data) begin
                        state_d = S_CRASH;
                    end else begin
                        state_d      = S_RUN;
                        x_d          = nx_q;
                        y_d          = ny_q;
                        addr_d       = rd_addr_q;
                        step_valid_d = 1'b1;
                        cnt_d        = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            dir_q        <= D_DOWN;
            cnt_q        <= '0;
            x_q          <= START_XV;
            y_q          <= START_YV;
            addr_q       <= START_ADDR;
            nx_q         <= '0;
            ny_q         <= '0;
            rd_addr_q    <= '0;
            rd_req_q     <= 1'b0;
            step_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            nx_q         <= nx_d;
            ny_q         <= ny_d;
            rd_addr_q    <= rd_addr_d;
            rd_req_q     <= rd_req_d;
            step_valid_q <= step_valid_d;
        end
    end

    assign rd.rd_req   = rd_req_q;
    assign rd.rd_addr  = rd_addr_q;
    assign x           = x_q;
    assign y           = y_q;
    assign addr        = addr_q;
    assign step_valid  = step_valid_q;
    assign running     = (state_q == S_RUN) || (state_q == S_CHECK);
    assign crashed     = (state_q == S_CRASH);
    assign dbg_state_o = state_q;

endmodule
